// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw PS/2 clock/data
// pair, frames 11-bit serial words, checks start/parity/stop, and folds the
// E0 (extended) and F0 (release) prefixes into flags so that every key event
// is delivered as a single strobe.
//
// Output semantics: strobe is a one-clock pulse with no backpressure; code,
// released and extended are valid while strobe=1 and hold until the next
// strobe. error is a one-clock pulse and never coincides with strobe.
module ps2_scancode_rx #(
   parameter int FILTER  = 8,
   parameter int TOW     = 14,
   parameter int TIMEOUT = 8000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   input  logic [1:0] ps2,
   output logic       strobe,
   output logic [7:0] code,
   output logic       released,
   output logic       extended,
   output logic       error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam logic [TOW-1:0] TMO_LAST = TOW'(TIMEOUT - 1);
   localparam logic [7:0]     PFX_EXT  = 8'hE0;
   localparam logic [7:0]     PFX_REL  = 8'hF0;

   // synchronisers and filter
   logic              clk_s1, clk_s2;
   logic              dat_s1, dat_s2;
   logic [FILTER-1:0] filt_sh;
   logic [FILTER-1:0] filt_sh_next;
   logic              filt_clk;
   logic              fall;

   // framing state (state is kept as a named enum so checkers can bind to it)
   state_t            state, state_next;
   logic [2:0]        bitcnt, bitcnt_next;
   logic [7:0]        shreg, shreg_next;
   logic              par_bit, par_next;
   logic              start_err;
   logic              frame_done;
   logic              frame_ok;
   logic              frame_bad;

   // prefixes and timeout
   logic              ext_flag, rel_flag;
   logic [TOW-1:0]    tmo_cnt;
   logic              tmo_hit;

   // two-flop synchronisers on both PS/2 lines, idle level is high
   always_ff @(posedge clock) begin
      if (!reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2[0];
         clk_s2 <= clk_s1;
         dat_s1 <= ps2[1];
         dat_s2 <= dat_s1;
      end
   end

   // filter window including this tick's sample; falling edge when it is all zeros
   always_comb begin
      filt_sh_next = {filt_sh[FILTER-2:0], clk_s2};
      fall         = ce && filt_clk && (filt_sh_next == '0);
   end

   // glitch filter: level changes only after FILTER identical ce samples
   always_ff @(posedge clock) begin
      if (!reset) begin
         filt_sh  <= '1;
         filt_clk <= 1'b1;
      end else if (ce) begin
         filt_sh <= filt_sh_next;
         if (filt_sh_next == '1) begin
            filt_clk <= 1'b1;
         end else if (filt_sh_next == '0) begin
            filt_clk <= 1'b0;
         end
      end
   end

   // timeout fires on a ce without an edge once the frame has been idle too long
   always_comb begin
      tmo_hit = ce && (state != IDLE) && !fall && (tmo_cnt >= TMO_LAST);
   end

   // inactivity counter: cleared in IDLE and on each edge, saturating otherwise
   always_ff @(posedge clock) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (ce) begin
         if ((state == IDLE) || fall) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

   // frame sequencing on filtered falling edges; an edge takes priority over timeout
   always_comb begin
      state_next  = state;
      bitcnt_next = bitcnt;
      shreg_next  = shreg;
      par_next    = par_bit;
      start_err   = 1'b0;
      frame_done  = 1'b0;
      if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state_next  = DATA;
                  bitcnt_next = 3'd0;
               end else begin
                  start_err = 1'b1;
               end
            end
            DATA: begin
               shreg_next  = {dat_s2, shreg[7:1]};
               bitcnt_next = bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  state_next = PARITY;
               end
            end
            PARITY: begin
               par_next   = dat_s2;
               state_next = STOP;
            end
            STOP: begin
               frame_done = 1'b1;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end else if (tmo_hit) begin
         state_next = IDLE;
      end
      frame_ok  = frame_done && dat_s2 && (^{shreg, par_bit});
      frame_bad = frame_done && !frame_ok;
   end

   // framing state register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         bitcnt  <= 3'd0;
         shreg   <= 8'h00;
         par_bit <= 1'b0;
      end else if (ce) begin
         state   <= state_next;
         bitcnt  <= bitcnt_next;
         shreg   <= shreg_next;
         par_bit <= par_next;
      end
   end

   // prefix folding and key-event outputs; strobe/error clear on every clock
   always_ff @(posedge clock) begin
      if (!reset) begin
         strobe   <= 1'b0;
         error    <= 1'b0;
         code     <= 8'h00;
         released <= 1'b0;
         extended <= 1'b0;
         ext_flag <= 1'b0;
         rel_flag <= 1'b0;
      end else begin
         strobe <= 1'b0;
         error  <= 1'b0;
         if (ce) begin
            if (frame_ok) begin
               if (shreg == PFX_EXT) begin
                  ext_flag <= 1'b1;
               end else if (shreg == PFX_REL) begin
                  rel_flag <= 1'b1;
               end else begin
                  code     <= shreg;
                  released <= rel_flag;
                  extended <= ext_flag;
                  strobe   <= 1'b1;
                  ext_flag <= 1'b0;
                  rel_flag <= 1'b0;
               end
            end else if (frame_bad || tmo_hit) begin
               error    <= 1'b1;
               ext_flag <= 1'b0;
               rel_flag <= 1'b0;
            end else if (start_err) begin
               error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames bit by bit and
// checks strobe/error pulse counts and the latched key-event outputs.
module tb_ps2_scancode_rx;

   localparam int HALF = 20;   // ce ticks per PS/2 clock half period

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ce    = 1'b0;
   logic [1:0] ps2   = 2'b11;
   logic       strobe;
   logic [7:0] code;
   logic       released;
   logic       extended;
   logic       error;

   int checks     = 0;
   int errors     = 0;
   int strobe_cnt = 0;
   int error_cnt  = 0;
   int s0, e0;

   ps2_scancode_rx dut (
      .clock    (clock),
      .reset    (reset),
      .ce       (ce),
      .ps2      (ps2),
      .strobe   (strobe),
      .code     (code),
      .released (released),
      .extended (extended),
      .error    (error)
   );

   // clock and ce generation: ce is high on every other clock
   always #5 clock = ~clock;

   initial begin
      forever begin
         @(negedge clock);
         ce = ~ce;
      end
   end

   // pulse monitor: counts high cycles of strobe and error, flags overlap
   always @(negedge clock) begin
      if (strobe) strobe_cnt++;
      if (error)  error_cnt++;
      if (strobe || error) begin
         checks++;
         assert (!(strobe && error)) else begin
            errors++;
            $error("FAIL strobe_error_overlap: observed strobe=%0b error=%0b required not both", strobe, error);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick_ce(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         while (ce !== 1'b1) @(posedge clock);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clock);
      ps2[1] = b;
      tick_ce(HALF);
      @(negedge clock);
      ps2[0] = 1'b0;
      tick_ce(HALF);
      @(negedge clock);
      ps2[0] = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(1'b1);
      tick_ce(30);
      @(negedge clock);
   endtask

   task automatic mark();
      s0 = strobe_cnt;
      e0 = error_cnt;
   endtask

   task automatic check_pulses(input string tag, input int exp_s, input int exp_e);
      check({tag, "_strobes"}, strobe_cnt - s0, exp_s);
      check({tag, "_errors"},  error_cnt - e0,  exp_e);
   endtask

   task automatic check_event(input string tag, input logic [7:0] c, input logic r, input logic x);
      check({tag, "_code"},     code,     c);
      check({tag, "_released"}, released, r);
      check({tag, "_extended"}, extended, x);
   endtask

   initial begin
      // reset state
      repeat (4) @(negedge clock);
      check("rst_strobe", strobe, 1'b0);
      check("rst_error",  error,  1'b0);
      check_event("rst", 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      tick_ce(20);

      // make code 1Ch
      mark();
      send_frame(8'h1C, 1'b0);
      check_pulses("make_1c", 1, 0);
      check_event("make_1c", 8'h1C, 1'b0, 1'b0);

      // break sequence F0 1C, then plain 1C
      mark();
      send_frame(8'hF0, 1'b1);
      check_pulses("brk_f0", 0, 0);
      send_frame(8'h1C, 1'b0);
      check_pulses("brk_1c", 1, 0);
      check_event("brk_1c", 8'h1C, 1'b1, 1'b0);
      mark();
      send_frame(8'h1C, 1'b0);
      check_pulses("make2_1c", 1, 0);
      check_event("make2_1c", 8'h1C, 1'b0, 1'b0);

      // extended release E0 F0 75
      mark();
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b1);
      check_pulses("ext_prefix", 0, 0);
      send_frame(8'h75, 1'b0);
      check_pulses("ext_75", 1, 0);
      check_event("ext_75", 8'h75, 1'b1, 1'b1);

      // parity fault after a pending F0: error, no strobe, outputs held
      mark();
      send_frame(8'hF0, 1'b1);
      send_frame(8'h1C, 1'b1);
      check_pulses("par_bad", 0, 1);
      check_event("par_hold", 8'h75, 1'b1, 1'b1);
      mark();
      send_frame(8'h1C, 1'b0);
      check_pulses("par_next", 1, 0);
      check_event("par_next", 8'h1C, 1'b0, 1'b0);

      // 3-ce glitches on the PS/2 clock while idle
      mark();
      for (int g = 0; g < 3; g++) begin
         @(negedge clock);
         ps2[0] = 1'b0;
         tick_ce(3);
         @(negedge clock);
         ps2[0] = 1'b1;
         tick_ce(20);
      end
      @(negedge clock);
      check_pulses("glitch", 0, 0);

      // stall after 5 bits until the inactivity timeout
      mark();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      tick_ce(7800);
      @(negedge clock);
      check_pulses("tmo_early", 0, 0);
      tick_ce(400);
      @(negedge clock);
      check_pulses("tmo_fire", 0, 1);
      mark();
      send_frame(8'h29, 1'b0);
      check_pulses("after_tmo", 1, 0);
      check_event("after_tmo", 8'h29, 1'b0, 1'b0);

      // reset pulse mid-frame
      mark();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      check("midrst_strobe", strobe, 1'b0);
      check("midrst_error",  error,  1'b0);
      check_event("midrst", 8'h00, 1'b0, 1'b0);
      tick_ce(20);
      @(negedge clock);
      check_pulses("midrst", 0, 0);
      mark();
      send_frame(8'h5A, 1'b1);
      check_pulses("after_rst", 1, 0);
      check_event("after_rst", 8'h5A, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Receives the raw PS/2 keyboard clock/data pair and delivers complete, checked scancode bytes.
- Resolves the E0 (extended) and F0 (release) prefixes into flags, so each key event arrives as one strobe.
- Sits between the PS/2 pins and the Lynx keyboard-matrix logic, which consumes strobe/code/released/extended to update the 10x8 matrix read on port 80h.
- Runs on the system clock, sampled on the 8 MHz clock-enable.

Parameters:
- FILTER, 8: number of consecutive identical samples needed to accept a new PS/2 clock level (glitch filter depth, 2..16).
- TOW, 14: width of the inactivity timeout counter.
- TIMEOUT, 8000: ce ticks without a PS/2 falling edge before a partial frame is aborted (about 1 ms at 8 MHz).

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-low reset.
- ce, input, 1: sample enable, one clock wide (8 MHz).
- ps2, input, 2: [0] PS/2 clock, [1] PS/2 data, both asynchronous.
- strobe, output, 1: one-clock pulse, a key event is valid.
- code, output, 8: scancode byte, with prefixes stripped.
- released, output, 1: F0 preceded code.
- extended, output, 1: E0 preceded code.
- error, output, 1: one-clock pulse on parity, start or stop error, or timeout.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low, sampled on the rising clock edge. All logic updates only when ce=1, except the strobe/error clear.
- Reset values: strobe=0, code=00h, released=0, extended=0, error=0. The FSM goes to IDLE, the filter is preloaded to all ones, and the prefix flags are cleared. Reset mid-frame discards the frame with no strobe and no error.
- Synchronisation: each ps2 bit passes through a 2-FF synchroniser on clock.
- Clock filter:
  - The filtered clock becomes 0 only after FILTER consecutive ce samples of 0, and 1 only after FILTER consecutive samples of 1.
  - A falling edge is a 1->0 transition of the filtered clock.
  - Data is sampled from the synchronised data bit at that same ce tick.
- FSM (advances only on falling edges; timeout runs on every ce):
  - IDLE: data=0 goes to DATA with bitcount=0. Data=1 is a start error: pulse error and stay in IDLE.
  - DATA: shift right, with the data bit entering bit 7 (LSB first). After the 8th bit, go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: the frame is good when stop=1 and XOR(byte, parity)=1 (odd parity). Any other case pulses error and clears both prefix flags. Always return to IDLE.
- Byte handling for a good frame:
  - E0h: set the extended flag; no strobe.
  - F0h: set the released flag; no strobe.
  - Any other byte (including E1h, AAh, FAh, FEh): code<=byte, released<=flag, extended<=flag, strobe=1 for exactly one clock, then clear both prefix flags.
- Flag persistence: code, released and extended hold until the next strobe.
- Latency: strobe is asserted on the clock following the ce tick of the 11th falling edge.
- Timeout:
  - The counter resets on each falling edge and increments on each ce while not in IDLE.
  - Reaching TIMEOUT aborts the frame: return to IDLE, pulse error, clear the prefix flags.
  - The counter saturates and never wraps.
  - In IDLE the counter is held at 0.
- Simultaneous events: if a falling edge and a timeout occur on the same ce, the edge wins. The counter clears and no error is raised.
- strobe and error are never asserted in the same clock.

Test Plan:
- Make frame 1Ch: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1, at 12 kHz -> one strobe, code=1Ch, released=0, extended=0, error=0.
- Break sequence: frame F0h, then frame 1Ch -> no strobe after F0h. After 1Ch: strobe, code=1Ch, released=1, extended=0. A following plain 1Ch gives released=0.
- Extended release: frames E0h, F0h, 75h -> a single strobe with code=75h, released=1, extended=1.
- Parity fault: frame 1Ch sent with parity 1 -> error pulse, no strobe, code stays at its previous value. A pending F0 flag is cleared (verify on the next good frame).
- Noise and timeout: 3-ce low glitches on the PS/2 clock in IDLE -> no state change. Stop after 5 bits for more than 8000 ce -> single error pulse. Then a clean 29h frame -> strobe, code=29h.
- Reset mid-frame: drive reset low for one clock after the 4th bit -> all outputs 0, no strobe. A complete 5Ah frame then gives strobe, code=5Ah.
